// File: rtl/mips_pkg.sv
// Constants and types shared between the ALU and the multiply/divide unit.
package mips_pkg;

   localparam logic [3:0] SEL_MUL = 4'b1000;
   localparam logic [3:0] SEL_DIV = 4'b1010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIN  = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit feeding hi/lo.
//
// state | meaning
// IDLE  | waiting for start with a MUL/DIV selector
// MUL   | one shift-add step per cycle, 32 steps
// DIV   | one restoring shift-subtract step per cycle, 32 steps (skipped on divisor 0)
// FIN   | load hi/lo/div_zero, raise done on the next cycle
module muldiv_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       selector,
   input  logic [WIDTH-1:0] Data1,
   input  logic [WIDTH-1:0] Data2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   state_t                 r_state;
   state_t                 w_next;
   logic [2*WIDTH-1:0]     r_acc;
   logic [WIDTH-1:0]       r_b;
   logic [4:0]             r_cnt;
   logic                   r_is_div;
   logic                   r_done;
   logic [WIDTH-1:0]       r_hi;
   logic [WIDTH-1:0]       r_lo;
   logic                   r_dz;

   logic                   w_accept;
   logic                   w_last;
   logic                   w_dz;
   logic                   w_ge;
   logic [WIDTH:0]         w_sum;
   logic [WIDTH:0]         w_rem_sh;
   logic [WIDTH:0]         w_diff;

   always_comb begin
      w_accept = start && ((selector == SEL_MUL) || (selector == SEL_DIV));
      w_last   = (r_cnt == 5'd31);
      w_dz     = r_is_div && (r_b == '0);
      // Multiply keeps the multiplier in the low half; the carry lands in the shifted-in bit.
      w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
      w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
      w_diff   = w_rem_sh - {1'b0, r_b};
      w_ge     = (w_rem_sh >= {1'b0, r_b});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (start && (selector == SEL_MUL)) begin
               w_next = MUL;
            end else if (start && (selector == SEL_DIV)) begin
               w_next = DIV;
            end
         end
         MUL: if (w_last) w_next = FIN;
         DIV: if ((r_b == '0) || w_last) w_next = FIN;
         FIN: w_next = IDLE;
      endcase
   end

   always_comb begin
      busy     = (r_state != IDLE);
      done     = r_done;
      hi       = r_hi;
      lo       = r_lo;
      div_zero = r_dz;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_dz     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_acc    <= {{WIDTH{1'b0}}, Data1};
                  r_b      <= Data2;
                  r_is_div <= (selector == SEL_DIV);
                  r_cnt    <= '0;
               end
            end
            MUL: begin
               r_acc <= {w_sum, r_acc[WIDTH-1:1]};
               r_cnt <= r_cnt + 5'd1;
            end
            DIV: begin
               // Divisor 0 leaves the dividend untouched so it can be reported as the remainder.
               if (r_b != '0) begin
                  r_acc <= w_ge ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                                : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            FIN: begin
               r_done <= 1'b1;
               r_dz   <= w_dz;
               if (w_dz) begin
                  r_hi <= r_acc[WIDTH-1:0];
                  r_lo <= {WIDTH{1'b1}};
               end else begin
                  r_hi <= r_acc[2*WIDTH-1:WIDTH];
                  r_lo <= r_acc[WIDTH-1:0];
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed MUL/DIV vectors, overlap, reset and illegal-selector cases.
module tb_muldiv_unit;
   import mips_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  selector;
   logic [31:0] Data1;
   logic [31:0] Data2;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_zero;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          at_cyc;
   } exp_t;

   exp_t q[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .selector (selector),
      .Data1    (Data1),
      .Data2    (Data2),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation, including its edge.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
            check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
            check("done_edge", cyc, e.at_cyc);
         end
      end
   end

   // Called at a negedge: the next rising edge is the accepting edge.
   task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input int lat, input bit expect_done);
      exp_t e;
      start    = 1'b1;
      selector = sel;
      Data1    = a;
      Data2    = b;
      if (expect_done) begin
         e.hi = ehi; e.lo = elo; e.dz = edz; e.at_cyc = cyc + 1 + lat;
         q.push_back(e);
      end
      @(negedge clk);
      start    = 1'b0;
      selector = 4'($urandom);
      Data1    = $urandom;
      Data2    = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", {31'd0, (q.size() != 0 || busy)}, 32'd0);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wait_done_timeout", {31'd0, done}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; selector = 4'd0; Data1 = '0; Data2 = '0;
      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_dz", {31'd0, div_zero}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // MUL 7*6 with a DIV 9/3 request arriving at edge 5 while busy
      issue(SEL_MUL, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33, 1'b1);
      repeat (4) @(negedge clk);
      start = 1'b1; selector = SEL_DIV; Data1 = 32'd9; Data2 = 32'd3;
      @(negedge clk);
      check("busy_mid_mul", {31'd0, busy}, 32'd1);
      start = 1'b0;
      drain();

      issue(SEL_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b1);
      drain();
      issue(SEL_MUL, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33, 1'b1);
      drain();

      // DIV 100/7 then a DIV issued in the done cycle
      issue(SEL_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b1);
      wait_done();
      issue(SEL_DIV, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, 33, 1'b1);
      drain();
      issue(SEL_DIV, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0, 33, 1'b1);
      drain();
      issue(SEL_DIV, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, 33, 1'b1);
      drain();
      issue(SEL_DIV, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b0, 33, 1'b1);
      drain();

      // Divide by zero, then a MUL that must clear div_zero
      issue(SEL_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 2, 1'b1);
      drain();
      issue(SEL_MUL, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0, 33, 1'b1);
      drain();

      // Non-request selector
      start = 1'b1; selector = 4'b0010; Data1 = 32'd11; Data2 = 32'd12;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("illegal_busy", {31'd0, busy}, 32'd0);
         @(negedge clk);
      end
      check("illegal_hi_hold", hi, 32'd0);
      check("illegal_lo_hold", lo, 32'd9);

      // Reset at edge 10 of a MUL: no done, outputs cleared at once
      issue(SEL_MUL, 32'd7, 32'd6, 32'd0, 32'd0, 1'b0, 33, 1'b0);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_hi", hi, 32'd0);
      check("midrst_lo", lo, 32'd0);
      @(negedge clk); @(negedge clk);
      // Start sampled on the edge that releases reset
      rst_n = 1'b1;
      issue(SEL_MUL, 32'd5, 32'd4, 32'd0, 32'd20, 1'b0, 33, 1'b1);
      drain();
      repeat (5) @(negedge clk);
      check("queue_empty", q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
